// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and helpers.
// Contents:
//   ST_*          receiver FSM state encodings
//   PARITY_*      parity mode selectors, shared with the transmitter
//   clks_per_bit  rounded system clocks per line bit
package uart_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset, loads RST_VAL into both flops
//   d_i  in   asynchronous input
//   q_o  out  synchronised output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver (optional parity) with valid/ready output and error pulses.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rxd         asynchronous serial line, idle high
//   rx_data     received byte, held stable while rx_valid is high
//   rx_valid    byte pending, cleared after rx_valid && rx_ready
//   rx_ready    consumer can accept a byte
//   frame_err   1-clk pulse, stop bit sampled low
//   parity_err  1-clk pulse, parity mismatch
//   overrun     1-clk pulse, byte completed while previous one still pending
//   busy        receiver FSM is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam logic [TW-1:0] T_LO  = TW'(HALF - 1);
    localparam logic [TW-1:0] T_MID = TW'(HALF);
    localparam logic [TW-1:0] T_DEC = TW'(HALF + 1);
    localparam logic [TW-1:0] T_END = TW'(CPB - 1);

    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic          par_err_q, par_err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_q, frame_d, perr_q, perr_d, ovr_q, ovr_d;
    logic          mid, dec, bit_end, stop_dec, good, load;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rxd),
        .q_o(rxs)
    );

    // Majority of the three samples around mid-bit; only meaningful when dec is high.
    assign mid     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign dec     = tick_q == T_DEC;
    assign bit_end = tick_q == T_END;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!rxs) state_d = ST_START;
            ST_START:  if (dec && mid) state_d = ST_IDLE;
                       else if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && bit_q == 3'd7)
                           state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            // The stop bit is judged at mid-bit so the next start edge is never missed.
            ST_STOP:   if (dec) state_d = mid ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rxs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = state_q != ST_IDLE;
        stop_dec = state_q == ST_STOP && dec;
        good     = stop_dec && mid && !par_err_q;
        load     = good && (!rx_valid_q || rx_ready);
    end

    always_comb begin
        tick_d     = (state_d != state_q || bit_end || state_q == ST_IDLE || state_q == ST_BREAK)
                     ? '0 : tick_q + 1'b1;
        bit_d      = (state_q == ST_DATA) ? (bit_end ? bit_q + 3'd1 : bit_q) : 3'd0;
        s0_d       = (tick_q == T_LO) ? rxs : s0_q;
        s1_d       = (tick_q == T_MID) ? rxs : s1_q;
        shreg_d    = (state_q == ST_DATA && dec) ? {mid, shreg_q[7:1]} : shreg_q;
        par_err_d  = (state_q == ST_PARITY && dec) ? (mid ^ (^shreg_q) ^ (PARITY == PARITY_ODD))
                   : (state_q == ST_IDLE) ? 1'b0 : par_err_q;
        rx_data_d  = load ? shreg_q : rx_data_q;
        rx_valid_d = load || (rx_valid_q && !rx_ready);
        frame_d    = stop_dec && !mid;
        perr_d     = stop_dec && mid && par_err_q;
        ovr_d      = good && rx_valid_q && !rx_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            par_err_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            frame_q    <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            par_err_q  <= par_err_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            frame_q    <= frame_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (no-parity and even-parity instances).
module tb_uart_rx;
    localparam int CPB = 434;

    typedef struct {
        logic [7:0] data;
        int         xfer;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, rxd_p = 1'b1, rx_ready = 1'b1, ready_p = 1'b1;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_xfer = 0, n_frame = 0, n_par = 0, n_ovr = 0, vrun = 0, last_vrun = 0, rise_cyc = -1;
    int n_xfer_p = 0, n_par_p = 0, n_frame_p = 0;
    logic prev_v = 1'b0;
    logic [7:0] q[$], qp[$];

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200), .PARITY(0)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200), .PARITY(1)) dut_p (
        .clk(clk), .rst(rst), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_v = 1'b0;
            vrun = 0;
        end else begin
            if (rx_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
            if (rx_valid) vrun++;
            else if (vrun > 0) begin
                last_vrun = vrun;
                vrun = 0;
            end
            prev_v = rx_valid;
            if (rx_valid && rx_ready) begin
                n_xfer++;
                chk("xfer_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) chk("xfer_data", int'(rx_data), int'(q.pop_front()));
            end
            n_frame += int'(frame_err);
            n_par   += int'(parity_err);
            n_ovr   += int'(overrun);
            if (rx_valid_p && ready_p) begin
                n_xfer_p++;
                chk("p_xfer_expected", int'(qp.size() > 0), 1);
                if (qp.size() > 0) chk("p_xfer_data", int'(rx_data_p), int'(qp.pop_front()));
            end
            n_par_p   += int'(parity_err_p);
            n_frame_p += int'(frame_err_p);
        end
    end

    task automatic hold(input logic v, input int n, input bit p);
        if (p) rxd_p = v;
        else rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int par, input bit p);
        hold(1'b0, CPB, p);
        for (int i = 0; i < 8; i++) hold(d[i], CPB, p);
        if (par >= 0) hold(par[0], CPB, p);
        hold(stop, CPB, p);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[4];
        int b_x, b_f, b_o, start_c, lat;
        logic [7:0] b;
        tbl = '{'{8'hDD, 2}, '{8'h01, 3}, '{8'h04, 4}, '{8'h06, 5}};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_errs", int'({frame_err, parity_err, overrun}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 20, 0);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // single byte, ready high
        q.push_back(8'hDD);
        start_c = cyc;
        send(8'hDD, 1'b1, -1, 0);
        hold(1'b1, 20, 0);
        lat = rise_cyc - start_c;
        chk("t1_xfer", n_xfer, 1);
        chk("t1_latency_ok", int'(lat >= 4115 && lat <= 4140), 1);
        if (lat < 4115 || lat > 4140) $display("t1 latency was %0d clocks", lat);
        chk("t1_valid_len", last_vrun, 1);
        chk("t1_errs", n_frame + n_par + n_ovr, 0);

        // back-to-back bytes
        for (int i = 0; i < 4; i++) begin
            q.push_back(tbl[i].data);
            send(tbl[i].data, 1'b1, -1, 0);
            chk($sformatf("vec%0d_xfer", i), n_xfer, tbl[i].xfer);
        end
        hold(1'b1, CPB, 0);
        chk("t2_queue_empty", q.size(), 0);
        chk("t2_errs", n_frame + n_par + n_ovr, 0);
        chk("t2_busy", int'(busy), 0);

        // start-bit glitch
        b_x = n_xfer; b_f = n_frame;
        hold(1'b0, 50, 0);
        @(negedge clk);
        chk("t3_busy_hi", int'(busy), 1);
        hold(1'b0, 50, 0);
        hold(1'b1, 2 * CPB, 0);
        @(negedge clk);
        chk("t3_busy_lo", int'(busy), 0);
        chk("t3_no_xfer", n_xfer - b_x, 0);
        chk("t3_no_frame", n_frame - b_f, 0);

        // framing error then held break
        b_x = n_xfer; b_f = n_frame;
        send(8'h55, 1'b0, -1, 0);
        hold(1'b0, 3 * CPB, 0);
        @(negedge clk);
        chk("t4_busy_break", int'(busy), 1);
        chk("t4_one_frame", n_frame - b_f, 1);
        hold(1'b1, 10, 0);
        @(negedge clk);
        chk("t4_busy_lo", int'(busy), 0);
        chk("t4_still_one", n_frame - b_f, 1);
        chk("t4_no_xfer", n_xfer - b_x, 0);

        // overrun with ready low
        b_x = n_xfer; b_o = n_ovr;
        rx_ready = 1'b0;
        q.push_back(8'h01);
        send(8'h01, 1'b1, -1, 0);
        send(8'h02, 1'b1, -1, 0);
        hold(1'b1, CPB, 0);
        @(negedge clk);
        chk("t5_valid_held", int'(rx_valid), 1);
        chk("t5_data_kept", int'(rx_data), 1);
        chk("t5_overrun", n_ovr - b_o, 1);
        chk("t5_no_xfer_yet", n_xfer - b_x, 0);
        hold(1'b1, 1, 0);
        rx_ready = 1'b1;
        hold(1'b1, 10, 0);
        @(negedge clk);
        chk("t5_one_xfer", n_xfer - b_x, 1);
        chk("t5_valid_clr", int'(rx_valid), 0);
        chk("t5_queue_empty", q.size(), 0);

        // reset in the middle of a frame
        b_x = n_xfer; b_f = n_frame;
        b = 8'h3C;
        hold(1'b0, CPB, 0);
        for (int i = 0; i < 4; i++) hold(b[i], CPB, 0);
        hold(b[4], 200, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_valid", int'(rx_valid), 0);
        chk("t6_rst_data", int'(rx_data), 0);
        chk("t6_rst_errs", int'({frame_err, parity_err, overrun}), 0);
        hold(1'b1, 4, 0);
        rst = 1'b0;
        hold(1'b1, CPB, 0);
        q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1, 0);
        hold(1'b1, 20, 0);
        chk("t6_one_xfer", n_xfer - b_x, 1);
        chk("t6_queue_empty", q.size(), 0);
        chk("t6_no_frame", n_frame - b_f, 0);

        // even parity instance
        send(8'h03, 1'b1, 1, 1);
        hold(1'b1, 20, 1);
        chk("t7_parity_err", n_par_p, 1);
        chk("t7_bad_no_xfer", n_xfer_p, 0);
        qp.push_back(8'h03);
        send(8'h03, 1'b1, 0, 1);
        hold(1'b1, 20, 1);
        chk("t7_good_xfer", n_xfer_p, 1);
        chk("t7_parity_once", n_par_p, 1);
        chk("t7_queue_empty", qp.size(), 0);
        chk("t7_no_frame", n_frame_p, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
